adau_spi_master: RTL and testbench

//  SPI master that serialises 32-bit ADAU1761 control words (8b chip addr, 16b reg addr, 8b data).

---
 rtl/adau_spi_master.sv | 120 ++++++++++++
 tb/tb_adau_spi_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adau_spi_master.sv
// SPI master for ADAU1761 control words: 32-bit frames, mode 3, MSB first.
// One frame per accepted command, then a CLATCH-high gap before the next accept.
module adau_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] command,
  input  logic        command_valid,
  output logic        spi_ready,
  output logic        busy,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [5:0]    bit_cnt;
  logic [31:0]   tx_shift;
  logic [31:0]   rx_shift;
  logic [1:0]    miso_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      miso_sync <= '0;
      spi_clk   <= 1'b1;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      spi_ready <= 1'b0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= '0;
    end else begin
      spi_ready <= 1'b0;
      rx_valid  <= 1'b0;
      miso_sync <= {miso_sync[0], spi_miso};
      case (state)
        IDLE: begin
          if (command_valid) begin
            tx_shift <= command;
            spi_mosi <= command[31];
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= DIV_LOAD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == '0) begin
            spi_clk <= 1'b0;
            div_cnt <= DIV_LOAD;
            bit_cnt <= 6'd31;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DW'(1);
          end else begin
            div_cnt <= DIV_LOAD;
            // spi_clk itself tells which half of the bit period just ended
            if (!spi_clk) begin
              spi_clk  <= 1'b1;
              rx_shift <= {rx_shift[30:0], miso_sync[1]};
            end else if (bit_cnt == '0) begin
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt - 6'd1;
              spi_clk  <= 1'b0;
              tx_shift <= {tx_shift[30:0], 1'b0};
              spi_mosi <= tx_shift[30];
            end
          end
        end
        HOLD: begin
          if (div_cnt == '0) begin
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            rx_data   <= rx_shift;
            spi_ready <= 1'b1;
            rx_valid  <= 1'b1;
            gap_cnt   <= GAP_LOAD;
            state     <= GAP;
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adau_spi_master.sv
// Bench for adau_spi_master: bus monitor decodes MOSI frames into a queue that is
// compared against words queued when each command is driven.
module tb_adau_spi_master;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] command, command1;
  logic        command_valid, command_valid1;
  logic        spi_ready, busy, rx_valid, spi_clk, spi_cs_n, spi_mosi, spi_miso;
  logic [31:0] rx_data, rx_data1;
  logic        spi_ready1, busy1, rx_valid1, spi_clk1, spi_cs_n1, spi_mosi1;

  adau_spi_master #(.CLK_DIV(4), .CS_GAP(8)) dut (
    .clk(clk), .reset(reset), .command(command), .command_valid(command_valid),
    .spi_ready(spi_ready), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso));

  adau_spi_master #(.CLK_DIV(1), .CS_GAP(2)) dut1 (
    .clk(clk), .reset(reset), .command(command1), .command_valid(command_valid1),
    .spi_ready(spi_ready1), .busy(busy1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .spi_clk(spi_clk1), .spi_cs_n(spi_cs_n1), .spi_mosi(spi_mosi1), .spi_miso(1'b0));

  int passed = 0, total = 0, cyc = 0;
  logic [31:0] exp_q[$], got_q[$];
  int          rise_q[$];
  int          rise_cnt = 32, ready_cnt = 0, coinc_err = 0, gap_len = 0, min_gap = 1000;
  bit          gap_arm = 0;
  logic [31:0] mosi_word = '0, miso_word = '0;
  logic        prev_clk = 1'b1, prev_cs = 1'b1;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // bus monitor for the CLK_DIV=4 instance
  initial forever begin
    @(negedge clk);
    if (spi_ready === 1'b1) ready_cnt++;
    if (spi_ready !== rx_valid) coinc_err++;
    if (prev_cs && !spi_cs_n) begin
      rise_cnt  = 0;
      mosi_word = '0;
      if (gap_arm && gap_len < min_gap) min_gap = gap_len;
    end
    if (!spi_cs_n && !prev_clk && spi_clk) begin
      mosi_word = {mosi_word[30:0], spi_mosi};
      rise_cnt++;
    end
    if (!prev_cs && spi_cs_n) begin
      got_q.push_back(mosi_word);
      rise_q.push_back(rise_cnt);
      gap_len = 0;
      gap_arm = 1;
    end else if (spi_cs_n) begin
      gap_len++;
    end
    prev_cs  = spi_cs_n;
    prev_clk = spi_clk;
  end

  // slave model: mode 3, next bit driven on each falling SCLK
  initial begin
    spi_miso = 1'b0;
    forever begin
      @(negedge spi_clk);
      if (!spi_cs_n && rise_cnt < 32) spi_miso = miso_word[31 - rise_cnt];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    exp_q.delete(); got_q.delete(); rise_q.delete();
  endtask

  task automatic wait_ready(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (spi_ready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin total++; $display("FAIL %s: spi_ready timeout", name); end
  endtask

  task automatic wait_busy(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin total++; $display("FAIL %s: busy timeout", name); end
  endtask

  task automatic test_reset();
    reset = 1'b1; command = '0; command_valid = 1'b0; command1 = '0; command_valid1 = 1'b0;
    tick(4);
    total++;
    if ({spi_clk, spi_cs_n, spi_mosi, spi_ready, rx_valid, busy, rx_data} !== {6'b110000, 32'h0})
      $display("FAIL reset_state: got %b/%h want 110000/0",
               {spi_clk, spi_cs_n, spi_mosi, spi_ready, rx_valid, busy}, rx_data);
    else passed++;
    reset = 1'b0;
    tick(4);
    flush();
  endtask

  task automatic test_single_frame();
    bit ok; int t0, r0, rc; logic [31:0] e, g;
    r0 = ready_cnt;
    command = 32'h0040_1C21; command_valid = 1'b1; exp_q.push_back(command);
    wait_busy("single_busy", ok);
    if (!ok) return;
    t0 = cyc; command_valid = 1'b0;
    wait_ready("single_ready", ok);
    if (!ok) return;
    total++;
    if (cyc - t0 != 264) $display("FAIL single_latency: got %0d want 264", cyc - t0);
    else passed++;
    tick(20);
    total++;
    if (ready_cnt - r0 != 1) $display("FAIL single_ready_count: got %0d want 1", ready_cnt - r0);
    else passed++;
    total++;
    if (got_q.size() != 1) $display("FAIL single_frames: got %0d want 1", got_q.size());
    else begin
      e = exp_q.pop_front(); g = got_q.pop_front(); rc = rise_q.pop_front();
      if (g !== e || rc != 32) $display("FAIL single_word: got %h/%0d rises want %h/32", g, rc, e);
      else passed++;
    end
    flush();
  endtask

  task automatic test_command_list();
    logic [31:0] words [15] = '{32'h0, 32'h0, 32'h0, 32'h0040_0001, 32'h0040_0A00,
      32'h0040_1501, 32'h0040_1C21, 32'h0040_1D00, 32'h0040_1E41, 32'h0040_1F00,
      32'h0040_2003, 32'h0040_2103, 32'h0040_2903, 32'h0040_F201, 32'h0040_F301};
    bit ok; int r0, n, bad_rise; logic [31:0] e, g;
    r0 = ready_cnt; gap_arm = 0; min_gap = 1000; bad_rise = 0;
    for (int i = 0; i < 15; i++) begin
      command = words[i]; command_valid = 1'b1; exp_q.push_back(words[i]);
      wait_ready("list_ready", ok);
      if (!ok) break;
    end
    command_valid = 1'b0;
    tick(40);
    total++;
    if (got_q.size() != 15) $display("FAIL list_frame_count: got %0d want 15", got_q.size());
    else passed++;
    total++;
    if (ready_cnt - r0 != 15) $display("FAIL list_ready_count: got %0d want 15", ready_cnt - r0);
    else passed++;
    n = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (rise_q.pop_front() != 32) bad_rise++;
      total++;
      if (g !== e) $display("FAIL list_word%0d: got %h want %h", n, g, e);
      else passed++;
      n++;
    end
    total++;
    if (bad_rise != 0) $display("FAIL list_rises: %0d frames without 32 rises, want 0", bad_rise);
    else passed++;
    total++;
    if (min_gap < 8) $display("FAIL list_gap: got %0d want >= 8", min_gap);
    else passed++;
    flush();
  endtask

  task automatic test_readback();
    bit ok;
    miso_word = 32'hA5A5_0F0F;
    command = 32'h8040_0000; command_valid = 1'b1; exp_q.push_back(command);
    wait_busy("rb_busy", ok);
    if (!ok) return;
    command_valid = 1'b0;
    wait_ready("rb_ready", ok);
    if (!ok) return;
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 32'hA5A5_0F0F)
      $display("FAIL readback: got valid=%b data=%h want 1/a5a50f0f", rx_valid, rx_data);
    else passed++;
    tick(20);
    total++;
    if (coinc_err != 0) $display("FAIL rx_valid_coincident: got %0d mismatches want 0", coinc_err);
    else passed++;
    miso_word = '0;
    flush();
  endtask

  task automatic test_reset_abort();
    bit ok; int r0; logic [31:0] g;
    command = 32'h4000_1234; command_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rise_cnt >= 10 && !spi_cs_n) begin ok = 1; break; end
    end
    command_valid = 1'b0;
    if (!ok) begin total++; $display("FAIL abort_bit10: timeout"); return; end
    r0 = ready_cnt;
    reset = 1'b1;
    tick(1);
    total++;
    if ({spi_cs_n, spi_clk, spi_mosi, busy} !== 4'b1100)
      $display("FAIL abort_lines: got %b want 1100", {spi_cs_n, spi_clk, spi_mosi, busy});
    else passed++;
    reset = 1'b0;
    tick(300);
    total++;
    if (ready_cnt != r0) $display("FAIL abort_no_ready: got %0d pulses want 0", ready_cnt - r0);
    else passed++;
    flush();
    command = 32'h4000_5A3C; command_valid = 1'b1; exp_q.push_back(command);
    wait_busy("abort_busy", ok);
    if (!ok) return;
    command_valid = 1'b0;
    wait_ready("abort_ready", ok);
    if (!ok) return;
    tick(20);
    total++;
    if (got_q.size() != 1) $display("FAIL abort_refresh_frames: got %0d want 1", got_q.size());
    else begin
      g = got_q.pop_front();
      if (g !== exp_q[0] || rise_q[0] != 32)
        $display("FAIL abort_refresh_word: got %h/%0d want %h/32", g, rise_q[0], exp_q[0]);
      else passed++;
    end
    flush();
  endtask

  task automatic test_ignore_changes();
    bit ok; int r0; logic [31:0] g;
    r0 = ready_cnt;
    command = 32'h4017_00AA; command_valid = 1'b1; exp_q.push_back(command);
    wait_busy("ign_busy", ok);
    if (!ok) return;
    tick(40);
    command = 32'hFFFF_FFFF;
    tick(60);
    command_valid = 1'b0;
    wait_ready("ign_ready", ok);
    if (!ok) return;
    tick(40);
    total++;
    if (got_q.size() != 1) $display("FAIL ignore_frames: got %0d want 1", got_q.size());
    else begin
      g = got_q.pop_front();
      if (g !== exp_q.pop_front() || rise_q[0] != 32)
        $display("FAIL ignore_word: got %h want 401700aa", g);
      else passed++;
    end
    total++;
    if (busy !== 1'b0 || spi_cs_n !== 1'b1 || ready_cnt - r0 != 1)
      $display("FAIL ignore_idle: got busy=%b cs_n=%b pulses=%0d want 0/1/1", busy, spi_cs_n, ready_cnt - r0);
    else passed++;
    flush();
  endtask

  task automatic test_div1();
    bit ok; int t0, rises, first_rise, period; logic pclk; logic [31:0] w;
    command1 = 32'h0; command_valid1 = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy1 === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin total++; $display("FAIL div1_busy: timeout"); return; end
    t0 = cyc; command_valid1 = 1'b0; pclk = spi_clk1;
    rises = 0; first_rise = -1; period = -1; w = 32'hDEAD_BEEF; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!pclk && spi_clk1 && !spi_cs_n1) begin
        w = {w[30:0], spi_mosi1};
        if (rises == 0) first_rise = cyc;
        if (rises == 1) period = cyc - first_rise;
        rises++;
      end
      pclk = spi_clk1;
      if (spi_ready1 === 1'b1) begin ok = 1; break; end
    end
    total++;
    if (!ok || cyc - t0 != 66) $display("FAIL div1_latency: got %0d want 66", ok ? cyc - t0 : -1);
    else passed++;
    total++;
    if (period != 2) $display("FAIL div1_period: got %0d want 2", period);
    else passed++;
    total++;
    if (rises != 32 || w !== 32'h0) $display("FAIL div1_word: got %h/%0d rises want 0/32", w, rises);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_frame();
    test_command_list();
    test_readback();
    test_reset_abort();
    test_ignore_changes();
    test_div1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
